reg_scoreboard: RTL and testbench

Per-register write-pending tracker for the pipelined processor's issue stage, on the reader side of the 32-entry register file. Decode presents each instruction's source and destination registers. The block stalls issue while a source register still has an outstanding write. It counts issued writes and retires them as writeback commits into the register file. Register 0 is hardwired zero and is never pending.

---
 rtl/proc_pkg.sv | 6 +
 rtl/pending_counter.sv | 27 ++
 rtl/reg_scoreboard.sv | 74 +++++++
 tb/tb_reg_scoreboard.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Register-file constants shared by decode, the register file and the issue scoreboard.
package proc_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/pending_counter.sv
// One register's in-flight write count: saturating up/down counter with underflow flag.
module pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             underflow
);
    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && !dec && count != MAX)
            count <= count + CNT_W'(1);
        else if (dec && !inc && count != '0)
            count <= count - CNT_W'(1);
    end

    assign nonzero   = count != '0;
    // A simultaneous issue covers the retire, so only a lone retire at zero is an error.
    assign underflow = dec && !inc && count == '0;
endmodule

// File: rtl/reg_scoreboard.sv
// Issue-stage write-pending scoreboard: per-register in-flight counters and RAW/overflow stall.
module reg_scoreboard
    import proc_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                IssueValid,
    input  logic                IssueRegWrite,
    input  logic [ADDR_W-1:0]   IssueDest,
    input  logic [ADDR_W-1:0]   IssueSrc1,
    input  logic [ADDR_W-1:0]   IssueSrc2,
    input  logic                IssueUsesSrc2,
    input  logic                WbValid,
    input  logic [ADDR_W-1:0]   WbDest,
    output logic                Stall,
    output logic                Src1Busy,
    output logic                Src2Busy,
    output logic [NUM_REGS-1:0] PendingMask,
    output logic                ErrUnderflow
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] retire;
    logic [NUM_REGS-1:1] inc, uflow;
    logic [CNT_W-1:0]    c1, c2, cd;
    logic                dest_full, fire;

    assign cnt[0]         = '0;
    assign PendingMask[0] = 1'b0;

    always_comb begin
        retire = '0;
        for (int r = 1; r < NUM_REGS; r++)
            retire[r] = WbValid && WbDest == ADDR_W'(r);
    end

    // A source retiring its last write this cycle is readable via the write-then-read regfile.
    assign c1 = cnt[IssueSrc1];
    assign c2 = cnt[IssueSrc2];
    assign cd = cnt[IssueDest];
    assign Src1Busy  = c1 != '0 && !(c1 == CNT_W'(1) && retire[IssueSrc1]);
    assign Src2Busy  = IssueUsesSrc2 && c2 != '0 && !(c2 == CNT_W'(1) && retire[IssueSrc2]);
    assign dest_full = IssueRegWrite && IssueDest != REG_ZERO && cd == MAX && !retire[IssueDest];
    assign Stall     = IssueValid && (Src1Busy || Src2Busy || dest_full);
    assign fire      = IssueValid && !Stall && IssueRegWrite && IssueDest != REG_ZERO;

    always_comb begin
        inc = '0;
        for (int r = 1; r < NUM_REGS; r++)
            inc[r] = fire && IssueDest == ADDR_W'(r);
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        pending_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (Clk),
            .rst       (Reset),
            .inc       (inc[r]),
            .dec       (retire[r]),
            .count     (cnt[r]),
            .nonzero   (PendingMask[r]),
            .underflow (uflow[r])
        );
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            ErrUnderflow <= 1'b0;
        else if (|uflow)
            ErrUnderflow <= 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with an expected-value queue checked by immediate assertions.
module tb_reg_scoreboard;
    import proc_pkg::*;

    logic                Clk = 1'b0;
    logic                Reset = 1'b1;
    logic                IssueValid = 1'b0, IssueRegWrite = 1'b0, IssueUsesSrc2 = 1'b0, WbValid = 1'b0;
    logic [ADDR_W-1:0]   IssueDest = '0, IssueSrc1 = '0, IssueSrc2 = '0, WbDest = '0;
    logic                Stall, Src1Busy, Src2Busy, ErrUnderflow;
    logic [NUM_REGS-1:0] PendingMask;

    reg_scoreboard #(.CNT_W(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .IssueValid(IssueValid), .IssueRegWrite(IssueRegWrite), .IssueDest(IssueDest),
        .IssueSrc1(IssueSrc1), .IssueSrc2(IssueSrc2), .IssueUsesSrc2(IssueUsesSrc2),
        .WbValid(WbValid), .WbDest(WbDest),
        .Stall(Stall), .Src1Busy(Src1Busy), .Src2Busy(Src2Busy),
        .PendingMask(PendingMask), .ErrUnderflow(ErrUnderflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        tests++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL scoreboard_empty observed=%h expected=<queued value>", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic iv, input logic rw, input logic [ADDR_W-1:0] dest,
                         input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                         input logic u2, input logic wv, input logic [ADDR_W-1:0] wd);
        IssueValid = iv; IssueRegWrite = rw; IssueDest = dest;
        IssueSrc1 = s1; IssueSrc2 = s2; IssueUsesSrc2 = u2;
        WbValid = wv; WbDest = wd;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        push("rst_mask", 32'h0);  check(PendingMask);
        push("rst_err", 32'h0);   check({31'b0, ErrUnderflow});
        push("rst_stall", 32'h0); check({31'b0, Stall});
        Reset = 1'b0;
        tick();

        // First writer issues freely; pending bit appears one cycle later
        drive(1, 1, 5, 1, 2, 1, 0, 0);
        #1 push("issue5_stall", 32'h0); check({31'b0, Stall});
        tick();
        push("issue5_mask", 32'h0000_0020); check(PendingMask);

        // Dependent reader stalls, unless writeback commits the same cycle
        drive(1, 0, 0, 5, 0, 0, 0, 0);
        #1 push("raw5_stall", 32'h1); check({31'b0, Stall});
        push("raw5_busy1", 32'h1); check({31'b0, Src1Busy});
        WbValid = 1'b1; WbDest = 5;
        #1 push("raw5_wb_stall", 32'h0); check({31'b0, Stall});
        push("raw5_wb_busy1", 32'h0); check({31'b0, Src1Busy});
        tick();
        push("raw5_wb_mask", 32'h0); check(PendingMask);

        // Src2 hazard, gated by IssueUsesSrc2
        drive(1, 1, 6, 0, 0, 0, 0, 0);
        tick();
        push("issue6_mask", 32'h0000_0040); check(PendingMask);
        drive(1, 0, 0, 0, 6, 1, 0, 0);
        #1 push("src2_busy", 32'h1); check({31'b0, Src2Busy});
        push("src2_stall", 32'h1); check({31'b0, Stall});
        IssueUsesSrc2 = 1'b0;
        #1 push("src2_unused_busy", 32'h0); check({31'b0, Src2Busy});
        push("src2_unused_stall", 32'h0); check({31'b0, Stall});
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 6);
        tick();
        push("retire6_mask", 32'h0); check(PendingMask);

        // Fill counter[7] to its maximum of 3, then DestFull
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 7, 0, 0, 0, 0, 0);
            #1 push("fill7_stall", 32'h0); check({31'b0, Stall});
            tick();
        end
        push("fill7_mask", 32'h0000_0080); check(PendingMask);
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        #1 push("full7_stall", 32'h1); check({31'b0, Stall});
        WbValid = 1'b1; WbDest = 7;
        #1 push("full7_wb_stall", 32'h0); check({31'b0, Stall});
        tick();
        push("full7_wb_mask", 32'h0000_0080); check(PendingMask);

        // Drain counter[7]: still 3 pending, so three retires needed; busy ignores IssueValid
        for (int n = 3; n >= 1; n--) begin
            drive(0, 0, 0, 7, 0, 0, 1, 7);
            #1 push("drain7_busy1", (n > 1) ? 32'h1 : 32'h0); check({31'b0, Src1Busy});
            push("drain7_stall", 32'h0); check({31'b0, Stall});
            tick();
            push("drain7_mask", (n > 1) ? 32'h0000_0080 : 32'h0); check(PendingMask);
        end
        push("drain7_err", 32'h0); check({31'b0, ErrUnderflow});

        // Register 0: never pending, never stalls, writeback ignored without error
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 1, 1, 0);
            #1 push("r0_stall", 32'h0); check({31'b0, Stall});
            tick();
            push("r0_mask", 32'h0); check(PendingMask);
            push("r0_err", 32'h0); check({31'b0, ErrUnderflow});
        end

        // Issue and retire on the same idle register cancel: no count, no underflow
        drive(1, 1, 8, 0, 0, 0, 1, 8);
        #1 push("both8_stall", 32'h0); check({31'b0, Stall});
        tick();
        push("both8_mask", 32'h0); check(PendingMask);
        push("both8_err", 32'h0); check({31'b0, ErrUnderflow});

        // Underflow on register 9 is sticky
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        push("uflow9_err", 32'h1); check({31'b0, ErrUnderflow});
        push("uflow9_mask", 32'h0); check(PendingMask);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        push("uflow9_sticky", 32'h1); check({31'b0, ErrUnderflow});

        // Asynchronous reset mid-cycle with pending writes and a stalled reader
        drive(1, 1, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4, 0, 0, 0, 0, 0);
        tick();
        push("pre_rst_mask", 32'h0000_0018); check(PendingMask);
        drive(1, 0, 0, 3, 0, 0, 0, 0);
        #1 push("pre_rst_stall", 32'h1); check({31'b0, Stall});
        #1 Reset = 1'b1;
        #1 push("async_rst_mask", 32'h0); check(PendingMask);
        push("async_rst_stall", 32'h0); check({31'b0, Stall});
        push("async_rst_busy1", 32'h0); check({31'b0, Src1Busy});
        push("async_rst_err", 32'h0); check({31'b0, ErrUnderflow});
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        Reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
